// File: rtl/cheri_rvk_ctrl.sv
// cheri_rvk_ctrl: reserves capability-load destinations, checks loaded heap
// capabilities against the revocation bitmap and releases registers in order.
module cheri_rvk_ctrl #(
  parameter int unsigned Depth    = 2,
  parameter logic [31:0] RevBase  = 32'h0000_0000,
  parameter logic [31:0] HeapBase = 32'h8000_0000,
  parameter logic [31:0] HeapSize = 32'h0004_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clc_req_i,
  input  logic [4:0]  clc_rd_i,
  output logic        clc_req_rdy_o,
  input  logic        clc_resp_valid_i,
  input  logic [4:0]  clc_resp_rd_i,
  input  logic        clc_resp_tag_i,
  input  logic [31:0] clc_resp_base_i,
  output logic        bm_req_o,
  output logic [31:0] bm_addr_o,
  input  logic        bm_gnt_i,
  input  logic        bm_rvalid_i,
  input  logic [31:0] bm_rdata_i,
  input  logic        bm_err_i,
  output logic [4:0]  trsv_addr_o,
  output logic        trsv_en_o,
  output logic [6:0]  trsv_par_o,
  output logic [4:0]  trvk_addr_o,
  output logic        trvk_en_o,
  output logic        trvk_clrtag_o,
  output logic [6:0]  trvk_par_o
);
  localparam int unsigned CW = $clog2(Depth + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RVK} state_e;
  typedef struct packed {
    logic [4:0]  rd;
    logic        look;
    logic [28:0] gran;
  } entry_t;
  state_e        state_q, state_d;
  entry_t        fifo_q [Depth];
  entry_t        fifo_d [Depth];
  entry_t        new_entry;
  logic [CW-1:0] cnt_q, cnt_d, credits_q, credits_d, wr_idx;
  logic          bm_req_q, bm_req_d, trvk_en_q, trvk_en_d, trvk_clrtag_q, trvk_clrtag_d;
  logic [31:0]   bm_addr_q, bm_addr_d, new_off;
  logic [4:0]    trvk_addr_q, trvk_addr_d;
  logic          push, pop, in_heap, unused_off;
  // Inverted Hsiao SECDED(39,32): an all-zero word encodes to check bits 7'h2a.
  function automatic logic [6:0] secded_inv(input logic [31:0] d);
    return {^(d & 32'h98505586), ^(d & 32'h2DCC624C), ^(d & 32'hC2C1323B),
            ^(d & 32'h31234ED1), ^(d & 32'h413D89AA), ^(d & 32'hDEBA8050),
            ^(d & 32'h2606BD25)} ^ 7'h2a;
  endfunction
  assign trsv_en_o     = clc_req_i & (clc_rd_i != 5'd0);
  assign trsv_addr_o   = trsv_en_o ? clc_rd_i : 5'd0;
  assign trsv_par_o    = secded_inv({26'b0, trsv_en_o, trsv_addr_o});
  assign trvk_par_o    = secded_inv({25'b0, trvk_en_q, trvk_clrtag_q, trvk_addr_q});
  assign clc_req_rdy_o = credits_q < CW'(Depth);
  assign bm_req_o      = bm_req_q;
  assign bm_addr_o     = bm_addr_q;
  assign trvk_en_o     = trvk_en_q;
  assign trvk_addr_o   = trvk_addr_q;
  assign trvk_clrtag_o = trvk_clrtag_q;
  // Offsets are kept as 8-byte granule indices; the low bits never matter.
  assign new_off    = clc_resp_base_i - HeapBase;
  assign unused_off = ^new_off[2:0];
  assign in_heap    = ({1'b0, clc_resp_base_i} >= {1'b0, HeapBase}) &&
                      ({1'b0, clc_resp_base_i} < ({1'b0, HeapBase} + {1'b0, HeapSize}));
  assign new_entry  = '{rd: clc_resp_rd_i, look: clc_resp_tag_i & in_heap, gran: new_off[31:3]};
  assign push       = clc_resp_valid_i & (clc_resp_rd_i != 5'd0);
  assign pop        = state_q == RVK;
  assign wr_idx     = cnt_q - CW'(pop);
  always_comb begin
    fifo_d = fifo_q;
    if (pop) for (int i = 0; i < int'(Depth) - 1; i++) fifo_d[i] = fifo_q[i+1];
    for (int i = 0; i < int'(Depth); i++) if (push && CW'(i) == wr_idx) fifo_d[i] = new_entry;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    credits_d = credits_q + CW'(trsv_en_o) - CW'(trvk_en_q);
  end
  always_comb begin
    state_d       = state_q;
    trvk_clrtag_d = 1'b0;
    unique case (state_q)
      IDLE: if (cnt_q != '0) state_d = fifo_q[0].look ? REQ : RVK;
      REQ:  if (bm_gnt_i) state_d = WAIT;
      WAIT: if (bm_rvalid_i) begin
        state_d       = RVK;
        trvk_clrtag_d = bm_err_i | bm_rdata_i[fifo_q[0].gran[4:0]];
      end
      RVK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bm_req_d    = state_d == REQ;
    bm_addr_d   = bm_req_d ? RevBase + {6'b0, fifo_q[0].gran[28:5], 2'b00} : 32'd0;
    trvk_en_d   = state_d == RVK;
    trvk_addr_d = trvk_en_d ? fifo_q[0].rd : 5'd0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fifo_q        <= '{default: '0};
      cnt_q         <= '0;
      credits_q     <= '0;
      bm_req_q      <= 1'b0;
      bm_addr_q     <= 32'd0;
      trvk_en_q     <= 1'b0;
      trvk_addr_q   <= 5'd0;
      trvk_clrtag_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      cnt_q         <= cnt_d;
      credits_q     <= credits_d;
      bm_req_q      <= bm_req_d;
      bm_addr_q     <= bm_addr_d;
      trvk_en_q     <= trvk_en_d;
      trvk_addr_q   <= trvk_addr_d;
      trvk_clrtag_q <= trvk_clrtag_d;
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && cnt_q == CW'(Depth) && !pop));
endmodule

// File: tb/tb_cheri_rvk_ctrl.sv
// tb_cheri_rvk_ctrl: directed and random stimulus for cheri_rvk_ctrl with a
// queue-based scoreboard, a granule-level revocation model and a SECDED decoder.
module tb_cheri_rvk_ctrl;
  localparam int unsigned Depth    = 2;
  localparam logic [31:0] RevBase  = 32'h1000_0000;
  localparam logic [31:0] HeapBase = 32'h8000_0000;
  localparam logic [31:0] HeapSize = 32'h0004_0000;
  localparam int unsigned NG       = HeapSize / 8;
  localparam logic [31:0] H [7] = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
                                    32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
  logic clk_i = 0, rst_ni = 1;
  logic clc_req_i = 0, clc_resp_valid_i = 0, clc_resp_tag_i = 0;
  logic [4:0] clc_rd_i = 0, clc_resp_rd_i = 0;
  logic [31:0] clc_resp_base_i = 0;
  logic bm_gnt_i = 0, bm_rvalid_i = 0, bm_err_i = 0;
  logic [31:0] bm_rdata_i = 0;
  logic clc_req_rdy_o, bm_req_o, trsv_en_o, trvk_en_o, trvk_clrtag_o;
  logic [31:0] bm_addr_o;
  logic [4:0] trsv_addr_o, trvk_addr_o;
  logic [6:0] trsv_par_o, trvk_par_o;

  cheri_rvk_ctrl #(.Depth(Depth), .RevBase(RevBase), .HeapBase(HeapBase), .HeapSize(HeapSize)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .clc_req_i(clc_req_i), .clc_rd_i(clc_rd_i), .clc_req_rdy_o(clc_req_rdy_o),
    .clc_resp_valid_i(clc_resp_valid_i), .clc_resp_rd_i(clc_resp_rd_i),
    .clc_resp_tag_i(clc_resp_tag_i), .clc_resp_base_i(clc_resp_base_i),
    .bm_req_o(bm_req_o), .bm_addr_o(bm_addr_o), .bm_gnt_i(bm_gnt_i),
    .bm_rvalid_i(bm_rvalid_i), .bm_rdata_i(bm_rdata_i), .bm_err_i(bm_err_i),
    .trsv_addr_o(trsv_addr_o), .trsv_en_o(trsv_en_o), .trsv_par_o(trsv_par_o),
    .trvk_addr_o(trvk_addr_o), .trvk_en_o(trvk_en_o), .trvk_clrtag_o(trvk_clrtag_o),
    .trvk_par_o(trvk_par_o));

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] addr; logic err;} lk_t;
  typedef struct {logic [4:0] rd; logic clr;} rl_t;
  lk_t lk_q[$];
  rl_t rl_q[$];
  logic [4:0] pend[$];
  bit revoked [NG];
  int n_chk = 0, n_pass = 0, inflight = 0, err_pct = 0;
  logic bm_auto = 0, rel_prev = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Syndrome of a received word; zero means the check bits are consistent.
  function automatic logic [6:0] ref_syndrome(input logic [31:0] d, input logic [6:0] c);
    logic [6:0] s;
    s = c ^ 7'h2a;
    for (int b = 0; b < 32; b++) for (int r = 0; r < 7; r++) s[r] ^= d[b] & H[r][b];
    return s;
  endfunction

  function automatic logic [31:0] bm_word(input logic [31:0] addr);
    logic [31:0] w;
    int unsigned idx;
    idx = (addr - RevBase) >> 2;
    for (int k = 0; k < 32; k++) w[k] = revoked[idx * 32 + k];
    return w;
  endfunction

  function automatic logic [31:0] pick_base();
    case ($urandom_range(0, 7))
      0: return HeapBase;
      1: return HeapBase + HeapSize - 1;
      2: return HeapBase + HeapSize;
      3: return 32'h7FFF_FFF8;
      4: return $urandom;
      default: return HeapBase + $urandom_range(0, HeapSize - 1);
    endcase
  endfunction

  // One cycle of LSU-side stimulus, driven at a falling edge; the model pushes
  // the expected release (and bitmap lookup) for every non-zero response.
  task automatic cyc(input logic req, input logic [4:0] rd, input logic rv,
                     input logic [4:0] rrd, input logic tag, input logic [31:0] base);
    logic en, look, err;
    longint unsigned b;
    int unsigned g;
    lk_t l;
    check("rdy", clc_req_rdy_o, inflight < Depth);
    clc_req_i = req; clc_rd_i = rd;
    clc_resp_valid_i = rv; clc_resp_rd_i = rrd; clc_resp_tag_i = tag; clc_resp_base_i = base;
    #1;
    en = req && rd != 0;
    check("trsv_en", trsv_en_o, en);
    check("trsv_addr", trsv_addr_o, en ? rd : 5'd0);
    check("trsv_par", ref_syndrome({26'b0, en, en ? rd : 5'd0}, trsv_par_o), 0);
    if (en) inflight++;
    if (rv && rrd != 0) begin
      b = base;
      look = tag && b >= HeapBase && b < 64'(HeapBase) + 64'(HeapSize);
      g = (base - HeapBase) >> 3;
      err = $urandom_range(0, 99) < err_pct;
      if (look) begin
        l.addr = RevBase + (g / 32) * 4;
        l.err = err;
        lk_q.push_back(l);
      end
      rl_q.push_back('{rrd, look ? (err | revoked[g]) : 1'b0});
    end
    @(negedge clk_i);
    clc_req_i = 0; clc_resp_valid_i = 0; clc_rd_i = 0; clc_resp_rd_i = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_checks();
    check("rst_rdy", clc_req_rdy_o, 1);
    check("rst_bm_req", bm_req_o, 0);
    check("rst_bm_addr", bm_addr_o, 0);
    check("rst_rvk_en", trvk_en_o, 0);
    check("rst_rvk_clr", trvk_clrtag_o, 0);
    check("rst_rvk_addr", trvk_addr_o, 0);
    check("rst_rvk_par", trvk_par_o, 7'h2a);
  endtask

  task automatic wait_bm_req();
    for (int i = 0; i < 20 && !bm_req_o; i++) @(negedge clk_i);
    check("bm_req_seen", bm_req_o, 1);
  endtask

  // Bitmap bus responder: random grant and data latency, junk strobes when idle.
  initial forever begin
    lk_t l;
    @(negedge clk_i);
    if (!bm_auto) continue;
    bm_gnt_i = 0; bm_rvalid_i = 0; bm_err_i = 0; bm_rdata_i = 0;
    if (bm_req_o) begin
      check("bm_lookup_expected", lk_q.size() != 0, 1);
      if (lk_q.size() == 0) continue;
      l = lk_q.pop_front();
      check("bm_addr", bm_addr_o, l.addr);
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk_i);
        check("bm_hold", {bm_req_o, bm_addr_o}, {1'b1, l.addr});
      end
      bm_gnt_i = 1;
      @(negedge clk_i);
      bm_gnt_i = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      bm_rvalid_i = 1; bm_err_i = l.err; bm_rdata_i = bm_word(l.addr);
    end else if ($urandom_range(0, 7) == 0) begin
      bm_gnt_i = 1; bm_rvalid_i = 1; bm_err_i = 1; bm_rdata_i = '1;
    end
  end

  // Release monitor: pops the scoreboard whenever a release strobe appears.
  initial forever begin
    rl_t r;
    @(posedge clk_i);
    #3;
    if (!rst_ni) begin rel_prev = 0; continue; end
    if (rel_prev) inflight--;
    rel_prev = trvk_en_o;
    check("trvk_par", ref_syndrome({25'b0, trvk_en_o, trvk_clrtag_o, trvk_addr_o}, trvk_par_o), 0);
    if (trvk_en_o) begin
      check("rvk_expected", rl_q.size() != 0, 1);
      if (rl_q.size() != 0) begin
        r = rl_q.pop_front();
        check("rvk_rd", trvk_addr_o, r.rd);
        check("rvk_clr", trvk_clrtag_o, r.clr);
      end
    end else check("rvk_idle", {trvk_addr_o, trvk_clrtag_o}, 0);
    if (!bm_req_o) check("bm_idle", bm_addr_o, 0);
  end

  initial begin
    logic rq, rv, tg;
    logic [4:0] rd, rrd;
    for (int g = 0; g < int'(NG); g++) revoked[g] = 1'($urandom_range(0, 1));
    #1 rst_ni = 0;
    repeat (2) @(negedge clk_i);
    reset_checks();
    rst_ni = 1;
    @(negedge clk_i);
    // Untagged load: release exactly two cycles after the response
    cyc(1, 5, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 5, 0, HeapBase);
    check("lat_early", trvk_en_o, 0);
    idle(1);
    check("lat_en", trvk_en_o, 1);
    check("lat_rd", trvk_addr_o, 5);
    check("lat_clr", trvk_clrtag_o, 0);
    idle(2);
    // Credit exhaustion
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 4, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 3, 0, 0);
    cyc(0, 0, 1, 4, 1, 32'h7FFF_FFF8);
    idle(6);
    // Revoked capability: granule 37 is bit 5 of bitmap word 1
    for (int k = 32; k < 64; k++) revoked[k] = (k == 37);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(0, 0, 1, 9, 1, 32'h8000_0128);
    wait_bm_req();
    check("rvk_bm_addr", bm_addr_o, RevBase + 4);
    lk_q.delete();
    bm_gnt_i = 1;
    @(negedge clk_i);
    bm_gnt_i = 0;
    check("wait_no_req", bm_req_o, 0);
    @(negedge clk_i);
    bm_rvalid_i = 1; bm_rdata_i = 32'h0000_0020;
    @(negedge clk_i);
    bm_rvalid_i = 0; bm_rdata_i = 0;
    check("rvk_en", trvk_en_o, 1);
    check("rvk_clrtag", trvk_clrtag_o, 1);
    check("rvk_addr", trvk_addr_o, 9);
    idle(2);
    // Reset while waiting for bitmap data
    cyc(1, 7, 0, 0, 0, 0);
    cyc(0, 0, 1, 7, 1, HeapBase + 32'h40);
    wait_bm_req();
    bm_gnt_i = 1;
    @(negedge clk_i);
    bm_gnt_i = 0;
    rst_ni = 0;
    #1;
    reset_checks();
    rl_q.delete(); lk_q.delete(); inflight = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    bm_rvalid_i = 1; bm_err_i = 1; bm_rdata_i = '1;
    @(negedge clk_i);
    bm_rvalid_i = 0; bm_err_i = 0; bm_rdata_i = 0;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_rvk", trvk_en_o, 0);
      @(negedge clk_i);
    end
    // Randomized traffic against the model
    bm_auto = 1;
    err_pct = 25;
    for (int c = 0; c < 3000; c++) begin
      rq = 0; rv = 0; rrd = 0;
      rd = 5'($urandom);
      tg = $urandom_range(0, 3) != 0;
      if (pend.size() != 0 && $urandom_range(0, 2) == 0) begin rv = 1; rrd = pend.pop_front(); end
      else if ($urandom_range(0, 15) == 0) rv = 1;
      if (inflight < Depth && $urandom_range(0, 1) == 1) rq = 1;
      if (rq && rd != 0) pend.push_back(rd);
      cyc(rq, rd, rv, rrd, tg, pick_base());
    end
    while (pend.size() != 0) begin
      rrd = pend.pop_front();
      cyc(0, 0, 1, rrd, 1, pick_base());
    end
    for (int i = 0; i < 300 && rl_q.size() != 0; i++) @(negedge clk_i);
    check("drain", rl_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cheri_rvk_ctrl.md
CHERI_RVK_CTRL -- requirements
Module: cheri_rvk_ctrl

Interface
REQ-001 SHALL have parameter Depth, default 2, pending load-capability entries (1..4).
REQ-002 SHALL have parameter RevBase, default 32'h0000_0000, byte address of the revocation bitmap.
REQ-003 SHALL have parameter HeapBase, default 32'h8000_0000, byte address of the first revocable granule.
REQ-004 SHALL have parameter HeapSize, default 32'h0004_0000, size in bytes of the revocable region.
REQ-005 SHALL have ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- clc_req_i, in, 1, load-capability accepted by LSU.
- clc_rd_i, in, 5, destination register of clc_req_i.
- clc_req_rdy_o, out, 1, credit available.
- clc_resp_valid_i, in, 1, load-capability data returned.
- clc_resp_rd_i, in, 5, destination register of the response.
- clc_resp_tag_i, in, 1, loaded capability tag.
- clc_resp_base_i, in, 32, loaded capability base.
- bm_req_o, out, 1, bitmap read request.
- bm_addr_o, out, 32, word-aligned bitmap address.
- bm_gnt_i, in, 1, request accepted.
- bm_rvalid_i, in, 1, read data valid.
- bm_rdata_i, in, 32, bitmap word.
- bm_err_i, in, 1, bus error, qualified by bm_rvalid_i.
- trsv_addr_o, out, 5, reserved register.
- trsv_en_o, out, 1, reservation strobe.
- trsv_par_o, out, 7, reservation check bits.
- trvk_addr_o, out, 5, released register.
- trvk_en_o, out, 1, release strobe.
- trvk_clrtag_o, out, 1, clear tag on release.
- trvk_par_o, out, 7, release check bits.

Function
REQ-006 SHALL drive trsv_en_o = clc_req_i & (clc_rd_i != 0), combinationally; trsv_addr_o = clc_rd_i when trsv_en_o, else 0.
REQ-007 SHALL keep a credit counter (0..Depth): +1 on trsv_en_o, -1 on a trvk_en_o cycle, unchanged when both occur; clc_req_rdy_o = (credits < Depth).
REQ-008 SHALL, on clc_resp_valid_i with clc_resp_rd_i != 0, push {rd, tag, base} into an in-order FIFO of Depth entries at the next edge; rd == 0 responses are dropped.
REQ-009 SHALL flag a pushed entry as needing lookup only if tag = 1 and HeapBase <= base < HeapBase+HeapSize (unsigned, 33-bit compare, no wrap).
REQ-010 SHALL use states IDLE, REQ, WAIT, RVK.
REQ-011 IDLE: if the FIFO is non-empty, go to REQ when the head needs lookup, else go to RVK with clrtag = 0.
REQ-012 REQ: hold bm_req_o = 1 and bm_addr_o stable; go to WAIT on bm_gnt_i.
REQ-013 WAIT: on bm_rvalid_i, latch clrtag = bm_err_i | bm_rdata_i[off[7:3]], where off = base - HeapBase; go to RVK.
REQ-014 RVK: assert trvk_en_o = 1 for exactly one cycle with trvk_addr_o = head rd and trvk_clrtag_o = latched clrtag; pop the head; return to IDLE.
REQ-015 SHALL compute bm_addr_o = RevBase + ((off >> 8) << 2), modulo 2^32.
REQ-016 SHALL drive bm_addr_o = 0 and bm_req_o = 0 outside REQ, and trvk_addr_o = trvk_clrtag_o = 0 outside RVK.
REQ-017 SHALL register all trvk_* and bm_* outputs, with no combinational path from any input.
REQ-018 SHALL, when push and pop occur in the same cycle, keep the FIFO count unchanged with entry order preserved.
REQ-019 SHALL never push while the FIFO is full; a push when full is a protocol violation, covered by an assertion only.
REQ-020 SHALL drive trsv_par_o as the 7 check bits of the inverted SECDED(39,32) encoding of {26'b0, trsv_en_o, trsv_addr_o}.
REQ-021 SHALL drive trvk_par_o as the 7 check bits of the inverted SECDED(39,32) encoding of {25'b0, trvk_en_o, trvk_clrtag_o, trvk_addr_o}.
REQ-022 SHALL produce check bits 7'h2a for an all-zero word under REQ-020 and REQ-021.
REQ-023 SHALL ignore bm_gnt_i outside REQ and bm_rvalid_i outside WAIT.

Reset
REQ-024 SHALL, while rst_ni = 0, hold state IDLE, FIFO empty, credits 0, clc_req_rdy_o = 1, bm_req_o = 0, bm_addr_o = 0, and trvk_en_o = trvk_clrtag_o = trvk_addr_o = 0.
REQ-025 SHALL hold trvk_par_o = 7'h2a while rst_ni = 0.
REQ-026 SHALL, on reset asserted mid-operation (REQ/WAIT/RVK), discard all entries and in-flight lookups immediately; late bm_rvalid_i after reset is ignored.

Verification
REQ-027 Untagged load: clc_req_i rd=5 at cycle 0 -> trsv_en_o=1, trsv_addr_o=5; clc_resp_valid_i tag=0 at cycle 3 -> trvk_en_o=1, addr=5, clrtag=0 at cycle 5, credits back to 0.
REQ-028 Revoked cap: base=32'h8000_0128, bm_rdata_i=32'h0000_0020, gnt same cycle as req, rvalid 2 cycles later -> bm_addr_o=RevBase+4, trvk_clrtag_o=1 one cycle after rvalid.
REQ-029 Out-of-range/bus error: tag=1 with base=32'h7FFF_FFF8 -> no bm_req_o, clrtag=0; in-range base with bm_err_i=1 -> clrtag=1.
REQ-030 Credits: Depth=2, two clc_req_i without responses -> clc_req_rdy_o=0; trvk_en_o on the same cycle as a new trsv_en_o -> credits stay 2, then drop to 1 on the next release.
REQ-031 Parity: idle -> trvk_par_o=7'h2a; random trsv/trvk values are checked against the reference SECDED(39,32) decoder with zero errors.
REQ-032 Reset in WAIT: assert rst_ni=0 with an entry pending -> all outputs at reset values, and no trvk_en_o after release even if bm_rvalid_i arrives.
